// File: rtl/pcie_scram_ctrl.sv
`default_nettype none
// ============================================================================
// pcie_scram_ctrl : per-symbol ordered-set parser driving scrambler seed/hold/bypass
// Revision 1.0
// ============================================================================
module pcie_scram_ctrl #(
  parameter int         TS_LEN  = 16,
  parameter logic [7:0] SYM_COM = 8'hBC,
  parameter logic [7:0] SYM_SKP = 8'h1C,
  parameter logic [7:0] SYM_PAD = 8'hF7
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  input  logic       k_in,
  input  logic       cfg_scram_disable,
  output logic       valid_out,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic       lfsr_seed,
  output logic       lfsr_hold,
  output logic       scram_bypass,
  output logic [1:0] os_type,
  output logic       err_ts_trunc
);

  localparam int            CW     = $clog2(TS_LEN);
  localparam logic [CW-1:0] C_LAST = CW'(TS_LEN - 1);

  typedef enum logic [2:0] {
    S_DATA     = 3'd0,
    S_OS_ID    = 3'd1,
    S_TS_BODY  = 3'd2,
    S_SKP_OS   = 3'd3,
    S_OTHER_OS = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_is_com;
  logic          w_is_skp;
  logic          w_seed;
  logic          w_hold;
  logic          w_byp;
  logic [1:0]    w_os;
  logic          w_err;

  assign w_is_com = k_in && (data_in == SYM_COM);
  assign w_is_skp = k_in && (data_in == SYM_SKP);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_DATA;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_seed     = 1'b0;
    w_hold     = 1'b0;
    w_byp      = 1'b1;
    w_os       = 2'd0;
    w_err      = 1'b0;
    if (!valid_in) begin
      // Idle slot: freeze the LFSR and keep the garbage byte unscrambled.
      w_hold = 1'b1;
    end else if (w_is_com) begin
      w_seed     = 1'b1;
      w_os       = 2'd3;
      w_err      = (r_state == S_TS_BODY);
      w_next     = S_OS_ID;
      w_cnt_next = CW'(1);
    end else begin
      case (r_state)
        S_OS_ID: begin
          if (w_is_skp) begin
            w_hold = 1'b1;
            w_os   = 2'd2;
            w_next = S_SKP_OS;
          end else if (!k_in || (data_in == SYM_PAD)) begin
            w_os       = 2'd1;
            w_next     = S_TS_BODY;
            w_cnt_next = CW'(2);
          end else begin
            w_os   = 2'd3;
            w_next = S_OTHER_OS;
          end
        end
        S_TS_BODY: begin
          w_os = 2'd1;
          if (r_cnt == C_LAST) begin
            w_next     = S_DATA;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_SKP_OS: begin
          if (w_is_skp) begin
            w_hold = 1'b1;
            w_os   = 2'd2;
          end else begin
            // End of SKP run: this symbol is already ordinary traffic.
            w_next     = S_DATA;
            w_cnt_next = '0;
            w_byp      = k_in;
          end
        end
        S_OTHER_OS: begin
          if (k_in) begin
            w_os = 2'd3;
          end else begin
            w_next     = S_DATA;
            w_cnt_next = '0;
            w_byp      = 1'b0;
          end
        end
        default: begin
          w_byp = k_in;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      valid_out    <= 1'b0;
      data_out     <= 8'h00;
      k_out        <= 1'b0;
      lfsr_seed    <= 1'b0;
      lfsr_hold    <= 1'b0;
      scram_bypass <= 1'b0;
      os_type      <= 2'd0;
      err_ts_trunc <= 1'b0;
    end else begin
      valid_out    <= valid_in;
      data_out     <= data_in;
      k_out        <= k_in;
      lfsr_seed    <= w_seed;
      lfsr_hold    <= w_hold & ~w_seed;
      scram_bypass <= w_byp | cfg_scram_disable;
      os_type      <= w_os;
      err_ts_trunc <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcie_scram_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pcie_scram_ctrl : directed stimulus, ordered-set model and literal checks
// Revision 1.0
// ============================================================================
module tb_pcie_scram_ctrl;

  logic       clk = 1'b0;
  logic       rstb;
  logic       valid_in;
  logic [7:0] data_in;
  logic       k_in;
  logic       cfg_scram_disable;
  logic       valid_out;
  logic [7:0] data_out;
  logic       k_out;
  logic       lfsr_seed;
  logic       lfsr_hold;
  logic       scram_bypass;
  logic [1:0] os_type;
  logic       err_ts_trunc;

  int n_total = 0;
  int n_bad   = 0;

  pcie_scram_ctrl dut (
    .clk               (clk),
    .rstb              (rstb),
    .valid_in          (valid_in),
    .data_in           (data_in),
    .k_in              (k_in),
    .cfg_scram_disable (cfg_scram_disable),
    .valid_out         (valid_out),
    .data_out          (data_out),
    .k_out             (k_out),
    .lfsr_seed         (lfsr_seed),
    .lfsr_hold         (lfsr_hold),
    .scram_bypass      (scram_bypass),
    .os_type           (os_type),
    .err_ts_trunc      (err_ts_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Model: position since the last COM and the ordered-set kind it announced.
  // kind: 0 none, 1 TS, 2 SKP, 3 other OS, 4 waiting for the identifier symbol
  int         m_since = 0;
  int         m_kind  = 0;
  logic       e_valid = 1'b0;
  logic [7:0] e_data  = 8'h00;
  logic       e_k     = 1'b0;
  logic       e_seed  = 1'b0;
  logic       e_hold  = 1'b0;
  logic       e_byp   = 1'b0;
  logic [1:0] e_os    = 2'd0;
  logic       e_err   = 1'b0;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_kind = 0; m_since = 0;
      e_valid = 0; e_data = 0; e_k = 0; e_seed = 0;
      e_hold = 0; e_byp = 0; e_os = 0; e_err = 0;
    end else begin
      e_valid = valid_in; e_data = data_in; e_k = k_in;
      e_seed = 0; e_hold = 0; e_err = 0; e_os = 0; e_byp = 1;
      if (!valid_in) begin
        e_hold = 1;
      end else if (k_in && data_in == 8'hBC) begin
        e_seed = 1; e_os = 3; e_err = (m_kind == 1);
        m_kind = 4; m_since = 0;
      end else if (m_kind == 4) begin
        m_since = 1;
        if (k_in && data_in == 8'h1C) begin
          m_kind = 2; e_hold = 1; e_os = 2;
        end else if (!k_in || data_in == 8'hF7) begin
          m_kind = 1; e_os = 1;
        end else begin
          m_kind = 3; e_os = 3;
        end
      end else if (m_kind == 1) begin
        m_since++;
        e_os = 1;
        if (m_since == 15) m_kind = 0;
      end else if (m_kind == 2 && k_in && data_in == 8'h1C) begin
        e_hold = 1; e_os = 2;
      end else if (m_kind == 3 && k_in) begin
        e_os = 3;
      end else begin
        m_kind = 0;
        e_byp = k_in;
      end
      e_byp = e_byp | cfg_scram_disable;
    end
  end

  always @(negedge clk) begin
    chk("valid_out", {7'd0, valid_out}, {7'd0, e_valid});
    chk("data_out", data_out, e_data);
    chk("k_out", {7'd0, k_out}, {7'd0, e_k});
    chk("lfsr_seed", {7'd0, lfsr_seed}, {7'd0, e_seed});
    chk("lfsr_hold", {7'd0, lfsr_hold}, {7'd0, e_hold});
    chk("scram_bypass", {7'd0, scram_bypass}, {7'd0, e_byp});
    chk("os_type", {6'd0, os_type}, {6'd0, e_os});
    chk("err_ts_trunc", {7'd0, err_ts_trunc}, {7'd0, e_err});
    chk("seed_hold_excl", {7'd0, lfsr_seed & lfsr_hold}, 8'd0);
  end

  task automatic send(input bit v, input bit k, input logic [7:0] d);
    valid_in = v; k_in = k; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input bit v, input bit sd, input bit h,
                     input bit b, input logic [1:0] os, input bit e);
    chk({n, ".valid"}, {7'd0, valid_out}, {7'd0, v});
    chk({n, ".seed"},  {7'd0, lfsr_seed}, {7'd0, sd});
    chk({n, ".hold"},  {7'd0, lfsr_hold}, {7'd0, h});
    chk({n, ".byp"},   {7'd0, scram_bypass}, {7'd0, b});
    if (v) chk({n, ".os"}, {6'd0, os_type}, {6'd0, os});
    chk({n, ".err"},   {7'd0, err_ts_trunc}, {7'd0, e});
  endtask

  initial begin
    rstb = 1'b1; valid_in = 1'b0; k_in = 1'b0; data_in = 8'h00;
    cfg_scram_disable = 1'b0;
    #2 rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit("reset", 0, 0, 0, 0, 2'd0, 0);
    chk("reset.data", data_out, 8'h00);
    rstb = 1'b1;

    // plain data
    for (int i = 0; i < 4; i++) begin
      send(1, 0, 8'h00);
      lit("s1_data", 1, 0, 0, 0, 2'd0, 0);
    end

    // full TS1: COM + 15 D
    send(1, 1, 8'hBC);
    lit("s2_com", 1, 1, 0, 1, 2'd3, 0);
    for (int i = 0; i < 15; i++) begin
      send(1, 0, 8'h01);
      lit("s2_ts", 1, 0, 0, 1, 2'd1, 0);
    end
    send(1, 0, 8'h55);
    lit("s2_after", 1, 0, 0, 0, 2'd0, 0);
    chk("s2_after.data", data_out, 8'h55);

    // SKP OS
    send(1, 1, 8'hBC);
    lit("s3_com", 1, 1, 0, 1, 2'd3, 0);
    for (int i = 0; i < 3; i++) begin
      send(1, 1, 8'h1C);
      lit("s3_skp", 1, 0, 1, 1, 2'd2, 0);
    end
    send(1, 0, 8'hAA);
    lit("s3_data", 1, 0, 0, 0, 2'd0, 0);

    // truncated TS
    send(1, 1, 8'hBC);
    send(1, 1, 8'hF7);
    lit("s4_pad", 1, 0, 0, 1, 2'd1, 0);
    for (int i = 0; i < 5; i++) send(1, 0, 8'h4A);
    send(1, 1, 8'hBC);
    lit("s4_trunc", 1, 1, 0, 1, 2'd3, 1);
    send(1, 0, 8'h4A);
    lit("s4_newid", 1, 0, 0, 1, 2'd1, 0);
    for (int i = 0; i < 14; i++) send(1, 0, 8'h4A);
    lit("s4_last", 1, 0, 0, 1, 2'd1, 0);
    send(1, 0, 8'h12);
    lit("s4_after", 1, 0, 0, 0, 2'd0, 0);

    // gap inside a TS after 7 valid symbols
    send(1, 1, 8'hBC);
    for (int i = 0; i < 6; i++) send(1, 0, 8'h02);
    for (int i = 0; i < 3; i++) begin
      send(0, 0, 8'h00);
      lit("s5_gap", 0, 0, 1, 1, 2'd0, 0);
    end
    for (int i = 0; i < 9; i++) begin
      send(1, 0, 8'h02);
      lit("s5_ts", 1, 0, 0, 1, 2'd1, 0);
    end
    send(1, 0, 8'h33);
    lit("s5_after", 1, 0, 0, 0, 2'd0, 0);

    // scrambling disabled around a SKP OS
    cfg_scram_disable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(1, 0, 8'h77);
      lit("s6_data", 1, 0, 0, 1, 2'd0, 0);
    end
    send(1, 1, 8'hBC);
    lit("s6_com", 1, 1, 0, 1, 2'd3, 0);
    for (int i = 0; i < 3; i++) begin
      send(1, 1, 8'h1C);
      lit("s6_skp", 1, 0, 1, 1, 2'd2, 0);
    end
    send(1, 0, 8'hAA);
    lit("s6_aa", 1, 0, 0, 1, 2'd0, 0);
    cfg_scram_disable = 1'b0;
    send(1, 0, 8'hAB);
    lit("s6_reen", 1, 0, 0, 0, 2'd0, 0);

    // other OS (FTS): stays bypassed on K, exits on first D
    send(1, 1, 8'hBC);
    send(1, 1, 8'h3C);
    lit("oth_id", 1, 0, 0, 1, 2'd3, 0);
    send(1, 1, 8'h3C);
    lit("oth_k", 1, 0, 0, 1, 2'd3, 0);
    send(1, 0, 8'h09);
    lit("oth_d", 1, 0, 0, 0, 2'd0, 0);

    // asynchronous reset in the middle of a TS
    send(1, 1, 8'hBC);
    send(1, 0, 8'h05);
    #2 rstb = 1'b0;
    #1;
    lit("arst", 0, 0, 0, 0, 2'd0, 0);
    @(posedge clk);
    #1 rstb = 1'b1;
    send(1, 0, 8'h06);
    lit("arst_after", 1, 0, 0, 0, 2'd0, 0);
    send(1, 1, 8'hBC);
    send(1, 0, 8'h06);
    lit("arst_ts", 1, 0, 0, 1, 2'd1, 0);

    send(0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
